core_mem_responder: RTL and testbench
=====================================

CORE_MEM_RESPONDER -- requirements
Module: core_mem_responder

Interface
REQ-001 SHALL have parameter NUM_OF_CORES, default 16, number of core memory ports.
REQ-002 SHALL have parameter REG_SIZE, default 8, data width per port.
REQ-003 SHALL have parameter ADDR_SIZE, default 8, address width per port.
REQ-004 SHALL have parameter ENABLE_SIZE, default 2, request code width: 00 idle, 01 read, 10 write, 11 write.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port enable, input, NUM_OF_CORES*ENABLE_SIZE, per-core request code; port i occupies slice i.
REQ-009 SHALL have port addr, input, NUM_OF_CORES*ADDR_SIZE, per-core address.
REQ-010 SHALL have port wr_data, input, NUM_OF_CORES*REG_SIZE, per-core write data.
REQ-011 SHALL have port rd_data, output, NUM_OF_CORES*REG_SIZE, per-core read data.
REQ-012 SHALL have port ready, output, NUM_OF_CORES, per-core one-cycle completion pulse.
REQ-013 SHALL have port hold, input, 1, display owns memory (driven by vga_en); no new grants.
REQ-014 SHALL have ports ram_we, output, 1, and ram_re, output, 1, the RAM write and read strobes.
REQ-015 SHALL have ports ram_addr, output, ADDR_SIZE, and ram_wdata, output, REG_SIZE, the RAM address and write data.
REQ-016 SHALL have port ram_rdata, input, REG_SIZE, RAM read data; synchronous RAM with 1-cycle read latency.

Function
REQ-017 SHALL run a two-state FSM: GRANT and RESP.
REQ-018 SHALL, in GRANT with hold=0 and at least one enable slice nonzero, select winner w as the first requesting port at or after pointer ptr, searching upward with wrap-around, then go to RESP.
REQ-019 SHALL stay in GRANT with all ram_* outputs zero when no port requests or hold=1.
REQ-020 SHALL, in the GRANT cycle of a grant, drive ram_addr/ram_wdata combinationally from port w, with ram_re=1 for code 01 and ram_we=1 for code 10 or 11.
REQ-021 SHALL update ptr to w+1 on grant, wrapping from NUM_OF_CORES-1 to 0.
REQ-022 SHALL, in RESP, assert ready[w]=1 only, drive rd_data slice w with ram_rdata on a read and zero on a write, and return to GRANT next cycle.
REQ-023 SHALL complete a RESP even if hold rises during it.
REQ-024 SHALL drive rd_data slices and ready bits of non-responding ports to zero.
REQ-025 SHALL give a fixed request-to-ready latency of 1 cycle when granted immediately, with one access per 2 cycles maximum throughput.
REQ-026 SHALL grant each continuously requesting port within 2*NUM_OF_CORES cycles while hold=0, so no port starves.
REQ-027 SHALL rely on the handshake rule that a core holds enable/addr/wr_data stable until its ready pulse, then idles or changes its request from the next cycle; a request withdrawn before grant is dropped silently.
REQ-028 SHALL keep all ram_* outputs zero in RESP.

Reset
REQ-029 SHALL, while reset=1, set the FSM to GRANT, ptr=0, all ready=0, all rd_data=0, and ram_we=ram_re=0.
REQ-030 SHALL, when reset is asserted during RESP, abort the response, emit no ready pulse, and leave any RAM write already strobed as performed.

Structure
REQ-031 SHALL take the enable codes, REG_SIZE/ADDR_SIZE/ENABLE_SIZE/NUM_OF_CORES defaults and bus-range macros from the shared defines header used by Core and sh_mem.
REQ-032 SHALL instantiate one sub-module, rr_arbiter: a combinational round-robin arbiter that takes the request vector and ptr and returns a one-hot grant and an index.
REQ-033 SHALL fit the complete implementation in 120-400 lines of RTL.

Verification
REQ-034 SHALL pass: port 3 reads addr 0x10 while the RAM model holds 0xA5 -> ram_re=1 with ram_addr=0x10 in cycle N, then ready[3]=1 and rd_data[3]=0xA5 in N+1.
REQ-035 SHALL pass: ports 0, 5 and 15 request simultaneously with ptr=0 -> grant order 0,5,15, with ready pulses at cycles N+1, N+3 and N+5.
REQ-036 SHALL pass: ptr=15 after grants, then ports 15 and 0 request -> 15 is granted first, then 0 (wrap-around).
REQ-037 SHALL pass: hold=1 for 10 cycles while port 2 writes 0x3C -> no ram_we during hold; ram_we with 0x3C one cycle after hold falls, then ready[2].
REQ-038 SHALL pass: reset asserted in RESP for port 7 -> ready[7] stays 0, ptr=0, and the next request from port 7 is granted normally.
REQ-039 SHALL pass: port 4 sends enable=11 -> ram_we=1 and rd_data[4]=0 on its ready pulse.

Source files
------------

// File: rtl/core_mem_responder_pkg.sv
// Shared widths, request codes and FSM states for the core memory responder.
// Imported by the responder top and its round-robin arbiter.
package core_mem_responder_pkg;

    localparam int DEF_NUM_OF_CORES = 16;
    localparam int DEF_REG_SIZE     = 8;
    localparam int DEF_ADDR_SIZE    = 8;
    localparam int DEF_ENABLE_SIZE  = 2;

    localparam logic [1:0] EN_IDLE      = 2'b00;
    localparam logic [1:0] EN_READ      = 2'b01;
    localparam logic [1:0] EN_WRITE     = 2'b10;
    localparam logic [1:0] EN_WRITE_ALT = 2'b11;

    typedef enum logic {
        ST_GRANT,
        ST_RESP
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr,
// searching upward with wrap-around.
module rr_arbiter
    import core_mem_responder_pkg::*;
#(
    parameter int N     = DEF_NUM_OF_CORES,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            if (!valid && req[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
        grant[idx] = valid;
    end

endmodule

// File: rtl/core_mem_responder.sv
// Shares one synchronous RAM among NUM_OF_CORES core ports.
// One access per GRANT/RESP pair, arbitrated round-robin.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int NUM_OF_CORES = DEF_NUM_OF_CORES,
    parameter int REG_SIZE     = DEF_REG_SIZE,
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int ENABLE_SIZE  = DEF_ENABLE_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_OF_CORES*ENABLE_SIZE-1:0] enable,
    input  logic [NUM_OF_CORES*ADDR_SIZE-1:0] addr,
    input  logic [NUM_OF_CORES*REG_SIZE-1:0]  wr_data,
    output logic [NUM_OF_CORES*REG_SIZE-1:0]  rd_data,
    output logic [NUM_OF_CORES-1:0]           ready,
    input  logic                              hold,
    output logic                              ram_we,
    output logic                              ram_re,
    output logic [ADDR_SIZE-1:0]              ram_addr,
    output logic [REG_SIZE-1:0]               ram_wdata,
    input  logic [REG_SIZE-1:0]               ram_rdata
);

    localparam int N     = NUM_OF_CORES;
    localparam int ES    = ENABLE_SIZE;
    localparam int IDX_W = idx_width(N);

    state_t state_q, state_d;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q;
    logic [N-1:0]     win_oh_q;
    logic             win_rd_q;

    logic [N-1:0]     req;
    logic [N-1:0]     gnt_oh;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             fire;

    logic [ES-1:0]        gnt_code;
    logic [ADDR_SIZE-1:0] gnt_addr;
    logic [REG_SIZE-1:0]  gnt_wdata;
    logic                 gnt_rd;

    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = |enable[i*ES +: ES];
        end
    end

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .valid (gnt_vld)
    );

    assign gnt_code  = enable[gnt_idx*ES +: ES];
    assign gnt_addr  = addr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
    assign gnt_wdata = wr_data[gnt_idx*REG_SIZE +: REG_SIZE];
    assign gnt_rd    = (gnt_code == ES'(EN_READ));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        fire      = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ready     = '0;
        rd_data   = '0;

        unique case (state_q)
            ST_GRANT: begin
                if (!hold && gnt_vld) begin
                    fire      = 1'b1;
                    ram_addr  = gnt_addr;
                    ram_wdata = gnt_wdata;
                    ram_re    = gnt_rd;
                    ram_we    = !gnt_rd;
                    state_d   = ST_RESP;
                    ptr_d     = (gnt_idx == IDX_W'(N-1))
                              ? '0 : gnt_idx + 1'b1;
                end
            end
            ST_RESP: begin
                ready = win_oh_q;
                if (win_rd_q) begin
                    rd_data[win_q*REG_SIZE +: REG_SIZE] = ram_rdata;
                end
                state_d = ST_GRANT;
            end
            default: state_d = ST_GRANT;
        endcase

        // Reset squashes the response in flight; a strobed write still lands.
        if (reset) begin
            fire      = 1'b0;
            ram_we    = 1'b0;
            ram_re    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
            ready     = '0;
            rd_data   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_GRANT;
            ptr_q    <= '0;
            win_q    <= '0;
            win_oh_q <= '0;
            win_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (fire) begin
                win_q    <= gnt_idx;
                win_oh_q <= gnt_oh;
                win_rd_q <= gnt_rd;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder with a 1-cycle synchronous RAM model.
module tb_core_mem_responder;

    localparam int N  = 16;
    localparam int RS = 8;
    localparam int AS = 8;
    localparam int ES = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*ES-1:0] enable;
    logic [N*AS-1:0] addr;
    logic [N*RS-1:0] wr_data;
    logic [N*RS-1:0] rd_data;
    logic [N-1:0]    ready;
    logic            hold;
    logic            ram_we;
    logic            ram_re;
    logic [AS-1:0]   ram_addr;
    logic [RS-1:0]   ram_wdata;
    logic [RS-1:0]   ram_rdata;

    logic [RS-1:0] mem [1<<AS];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         port;
        logic [1:0] code;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic       exp_re;
        logic       exp_we;
    } vec_t;

    vec_t vecs [7];
    vec_t v;
    int         ord  [4];
    logic [7:0] oexp [4];

    core_mem_responder #(
        .NUM_OF_CORES (N),
        .REG_SIZE     (RS),
        .ADDR_SIZE    (AS),
        .ENABLE_SIZE  (ES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .hold      (hold),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [1:0] code,
                           input logic [7:0] a, input logic [7:0] d);
        enable[p*ES +: ES] = code;
        addr[p*AS +: AS]   = a;
        wr_data[p*RS +: RS] = d;
    endtask

    task automatic clr_req(input int p);
        enable[p*ES +: ES] = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tx(input vec_t t, input string nm);
        logic [N-1:0]    er;
        logic [N*RS-1:0] ed;
        er = '0;
        ed = '0;
        er[t.port] = 1'b1;
        ed[t.port*RS +: RS] = t.exp_rd;
        set_req(t.port, t.code, t.a, t.wd);
        @(negedge clk);
        chk({nm, "_ram_re"}, ram_re, t.exp_re);
        chk({nm, "_ram_we"}, ram_we, t.exp_we);
        chk({nm, "_ram_addr"}, ram_addr, t.a);
        if (t.exp_we) chk({nm, "_ram_wdata"}, ram_wdata, t.wd);
        next_cycle();
        @(negedge clk);
        chk({nm, "_ready"}, ready, er);
        chk({nm, "_rd_data"}, rd_data, ed);
        chk({nm, "_resp_ram_idle"}, {ram_re, ram_we}, 2'b00);
        next_cycle();
        clr_req(t.port);
    endtask

    task automatic seq(input string nm, input int n);
        logic [N-1:0]    er;
        logic [N*RS-1:0] ed;
        for (int c = 0; c < 2*n; c++) begin
            @(negedge clk);
            er = '0;
            ed = '0;
            if (c % 2 == 1) begin
                er[ord[c/2]] = 1'b1;
                ed[ord[c/2]*RS +: RS] = oexp[c/2];
            end
            chk($sformatf("%s_c%0d_ready", nm, c), ready, er);
            chk($sformatf("%s_c%0d_rd_data", nm, c), rd_data, ed);
            if (c % 2 == 0) begin
                chk($sformatf("%s_c%0d_ram_addr", nm, c), ram_addr,
                    addr[ord[c/2]*AS +: AS]);
            end
            next_cycle();
            if (c % 2 == 1) clr_req(ord[c/2]);
        end
    endtask

    initial begin
        vecs[0] = '{1,  2'b10, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{3,  2'b01, 8'h10, 8'hEE, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{4,  2'b11, 8'h20, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{9,  2'b10, 8'h30, 8'h77, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{9,  2'b01, 8'h30, 8'hEE, 8'h77, 1'b1, 1'b0};
        vecs[5] = '{0,  2'b01, 8'h20, 8'hEE, 8'h5A, 1'b1, 1'b0};
        vecs[6] = '{15, 2'b01, 8'h10, 8'hEE, 8'hA5, 1'b1, 1'b0};

        reset   = 1'b1;
        hold    = 1'b0;
        enable  = '0;
        addr    = '0;
        wr_data = '0;
        set_req(5, 2'b01, 8'h10, 8'h00);
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_ram_we", ram_we, 0);
        next_cycle();
        reset = 1'b0;
        clr_req(5);
        @(negedge clk);
        chk("idle_ram", {ram_re, ram_we, ram_addr, ram_wdata}, 0);
        chk("idle_ready", ready, 0);
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            tx(vecs[i], $sformatf("vec%0d", i));
        end

        set_req(0,  2'b01, 8'h10, 8'h00);
        set_req(5,  2'b01, 8'h20, 8'h00);
        set_req(15, 2'b01, 8'h30, 8'h00);
        ord[0] = 0;  oexp[0] = 8'hA5;
        ord[1] = 5;  oexp[1] = 8'h5A;
        ord[2] = 15; oexp[2] = 8'h77;
        seq("order", 3);

        v = '{14, 2'b10, 8'h60, 8'h11, 8'h00, 1'b0, 1'b1};
        tx(v, "to_ptr15");
        set_req(15, 2'b01, 8'h60, 8'h00);
        set_req(0,  2'b01, 8'h10, 8'h00);
        ord[0] = 15; oexp[0] = 8'h11;
        ord[1] = 0;  oexp[1] = 8'hA5;
        seq("wrap", 2);

        hold = 1'b1;
        set_req(2, 2'b10, 8'h40, 8'h3C);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d", c), {ready, ram_re, ram_we}, 0);
            next_cycle();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("unhold_ram_we", ram_we, 1);
        chk("unhold_ram_wdata", ram_wdata, 8'h3C);
        chk("unhold_ram_addr", ram_addr, 8'h40);
        next_cycle();
        hold = 1'b1;
        @(negedge clk);
        chk("hold_in_resp_ready", ready, 16'h0004);
        chk("hold_in_resp_rd_data", rd_data, 0);
        next_cycle();
        hold = 1'b0;
        clr_req(2);
        v = '{2, 2'b01, 8'h40, 8'h00, 8'h3C, 1'b1, 1'b0};
        tx(v, "hold_readback");

        set_req(7, 2'b10, 8'h50, 8'h99);
        @(negedge clk);
        chk("p7_ram_we", ram_we, 1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("p7_rst_ready", ready, 0);
        chk("p7_rst_rd_data", rd_data, 0);
        next_cycle();
        reset = 1'b0;
        clr_req(7);
        set_req(7,  2'b01, 8'h50, 8'h00);
        set_req(10, 2'b01, 8'h10, 8'h00);
        ord[0] = 7;  oexp[0] = 8'h99;
        ord[1] = 10; oexp[1] = 8'hA5;
        seq("post_rst", 2);

        @(negedge clk);
        chk("final_idle", {ready, ram_re, ram_we}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
